// File: rtl/shift_rx_sequencer.sv
// shift_rx_sequencer: UART-style frame timing for an external LSB-first shift register, with a valid/ready byte holding stage.
module shift_rx_sequencer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  input  logic [7:0] shift_data,
  output logic       shift_enable,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clear_flags
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    out_byte_q, out_byte_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    out_byte_d   = out_byte_q;
    out_valid_d  = out_valid_q && !out_ready;
    frame_err_d  = frame_err_q && !clear_flags;
    overrun_d    = overrun_q && !clear_flags;
    shift_enable = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = serial_in ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = serial_in ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        shift_enable = 1'b1;
        cnt_d        = '0;
        bit_idx_d    = bit_idx_q + 1'b1;
        state_d      = (bit_idx_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = IDLE;
        if (!serial_in) frame_err_d = 1'b1;
        else if (!out_valid_q || out_ready) begin
          out_byte_d  = shift_data;
          out_valid_d = 1'b1;
        end else overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_shift_rx_sequencer.sv
// tb_shift_rx_sequencer: directed frames against hand-computed bit timing, with a behavioural capture register.
module tb_shift_rx_sequencer;
  localparam int N = 8;
  logic       clock = 1'b0;
  logic       reset, serial_in, shift_enable, out_valid, out_ready, busy, frame_err, overrun, clear_flags;
  logic [7:0] shift_data, out_byte, sr;
  int         n_cmp = 0, n_bad = 0;
  int         se_cnt, se_bad, v_first, glitch_se;
  logic [7:0] cap_byte;
  logic       cap_valid, busy4, busy5;

  shift_rx_sequencer #(.CLKS_PER_BIT(N)) dut (
    .clock(clock), .reset(reset), .serial_in(serial_in), .shift_data(shift_data),
    .shift_enable(shift_enable), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .clear_flags(clear_flags)
  );

  always #5 clock = ~clock;

  // Stand-in for the LSB-first capture register; new bit enters at bit 7.
  always_ff @(posedge clock)
    if (reset) sr <= '0;
    else if (shift_enable) sr <= {serial_in, sr[7:1]};
  assign shift_data = sr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      serial_in = 1'b1;
    end
  endtask

  // Negedge j drives the bit seen by edge E0+j and samples the cycle ending at E0+j.
  task automatic drive(input logic [7:0] d, input logic sb, input int len, input int rdy_j);
    int  b;
    logic exp_se;
    se_cnt = 0; se_bad = 0; v_first = -1; cap_byte = 'x; cap_valid = 1'bx;
    for (int j = 0; j < len; j++) begin
      @(negedge clock);
      b = j / N;
      serial_in = (b == 0) ? 1'b0 : (b >= 9) ? sb : d[b-1];
      if (rdy_j >= 0) out_ready = (j == rdy_j);
      exp_se = (j >= N/2 + N) && ((j - N/2) % N == 0) && (j <= N/2 + 8*N);
      if (shift_enable) se_cnt++;
      if (shift_enable !== exp_se) se_bad++;
      if (out_valid && v_first < 0) v_first = j;
      if (j == 10*N - 3) begin
        cap_byte  = out_byte;
        cap_valid = out_valid;
      end
    end
  endtask

  initial begin
    reset = 1'b1; serial_in = 1'b1; out_ready = 1'b0; clear_flags = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_se", shift_enable, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_byte", out_byte, 8'h00);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    idle(4);

    drive(8'hA5, 1'b1, 10*N, -1);
    chk("good_se_cnt", se_cnt, 8);
    chk("good_se_pos", se_bad, 0);
    chk("good_valid_edge", v_first, 77);
    chk("good_byte", out_byte, 8'hA5);
    chk("good_valid", out_valid, 1);
    chk("good_flags", {frame_err, overrun}, 0);
    @(negedge clock); out_ready = 1'b1;
    @(negedge clock); out_ready = 1'b0;
    chk("good_consumed", out_valid, 0);
    chk("good_idle", busy, 0);

    idle(4);
    glitch_se = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      serial_in = (j < 2) ? 1'b0 : 1'b1;
      if (shift_enable) glitch_se++;
      if (j == 4) busy4 = busy;
      if (j == 5) busy5 = busy;
    end
    chk("glitch_se", glitch_se, 0);
    chk("glitch_busy_e3", busy4, 1);
    chk("glitch_busy_e4", busy5, 0);
    chk("glitch_flags", {frame_err, overrun}, 0);
    chk("glitch_valid", out_valid, 0);

    drive(8'h3C, 1'b0, 10*N, -1);
    chk("ferr_set", frame_err, 1);
    chk("ferr_valid", out_valid, 0);
    chk("ferr_byte_kept", out_byte, 8'hA5);
    idle(12);
    chk("ferr_sticky", frame_err, 1);
    @(negedge clock); clear_flags = 1'b1;
    @(negedge clock); clear_flags = 1'b0;
    chk("ferr_cleared", frame_err, 0);

    idle(2);
    drive(8'h11, 1'b1, 10*N, -1);
    chk("ovr_first_byte", out_byte, 8'h11);
    chk("ovr_first_valid", out_valid, 1);
    drive(8'h22, 1'b1, 10*N, -1);
    chk("ovr_set", overrun, 1);
    chk("ovr_byte_kept", out_byte, 8'h11);
    chk("ovr_valid", out_valid, 1);
    chk("ovr_no_ferr", frame_err, 0);
    @(negedge clock); out_ready = 1'b1; clear_flags = 1'b1;
    @(negedge clock); out_ready = 1'b0; clear_flags = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("ovr_consumed", out_valid, 0);

    drive(8'h11, 1'b1, 10*N, -1);
    drive(8'h22, 1'b1, 10*N, 10*N - 4);
    chk("rdy_same_edge_byte", out_byte, 8'h22);
    chk("rdy_same_edge_valid", out_valid, 1);
    chk("rdy_same_edge_ovr", overrun, 0);

    drive(8'h0F, 1'b1, 42, -1);
    chk("mid_busy", busy, 1);
    @(negedge clock); reset = 1'b1; serial_in = 1'b1;
    @(negedge clock);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_se", shift_enable, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_byte", out_byte, 8'h00);
    chk("mid_rst_flags", {frame_err, overrun}, 0);
    reset = 1'b0;
    idle(4);
    drive(8'hFF, 1'b1, 10*N, -1);
    chk("post_rst_byte", out_byte, 8'hFF);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_se", se_cnt, 8);

    @(negedge clock); out_ready = 1'b1;
    drive(8'h00, 1'b1, 10*N, -1);
    chk("b2b0_valid", cap_valid, 1);
    chk("b2b0_byte", cap_byte, 8'h00);
    drive(8'hFF, 1'b1, 10*N, -1);
    chk("b2b1_valid", cap_valid, 1);
    chk("b2b1_byte", cap_byte, 8'hFF);
    chk("b2b1_se_pos", se_bad, 0);
    drive(8'h81, 1'b1, 10*N, -1);
    chk("b2b2_valid", cap_valid, 1);
    chk("b2b2_byte", cap_byte, 8'h81);
    chk("b2b_flags", {frame_err, overrun}, 0);
    idle(4);
    chk("b2b_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
